// File: rtl/game_status.sv
// Game status tracker: lives, score, pellets and win/death flags.
// Optional POWER_PELLET_EN adds fright mode and ghost eating.
module game_status #(
   parameter int HIT_DIST       = 8,
   parameter int PELLET_TOTAL   = 150,
   parameter int LIVES_INIT     = 3,
   parameter int RESPAWN_FRAMES = 60
`ifdef POWER_PELLET_EN
   ,
   parameter int FRIGHT_FRAMES  = 300
`endif
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        gamescreen,
   input  logic        frame_tick,
   input  logic [9:0]  pac_x,
   input  logic [9:0]  pac_y,
   input  logic [39:0] ghost_x,
   input  logic [39:0] ghost_y,
   input  logic        pellet_eaten,
`ifdef POWER_PELLET_EN
   input  logic        power_pellet,
   output logic [3:0]  ghost_eaten,
`endif
   output logic        pacDeath,
   output logic        winsignal,
   output logic [1:0]  lives,
   output logic [15:0] score,
   output logic [7:0]  pellets_left
);

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      RESPAWN,
      DEAD,
      WON
   } state_t;

   localparam logic [10:0] HD  = 11'(HIT_DIST);
   localparam logic [7:0]  PT  = 8'(PELLET_TOTAL);
   localparam logic [1:0]  LI  = 2'(LIVES_INIT);
   localparam logic [15:0] RF  = 16'(RESPAWN_FRAMES);

   state_t      state_q, state_d;
   logic [1:0]  lives_q, lives_d;
   logic [15:0] score_q, score_d;
   logic [7:0]  pel_q, pel_d;
   logic [15:0] resp_q, resp_d;
   logic        death_q, death_d;
   logic        win_q, win_d;
   logic [3:0]  hit;
`ifdef POWER_PELLET_EN
   localparam logic [15:0] FF = 16'(FRIGHT_FRAMES);
   logic [15:0] fright_q, fright_d;
   logic [3:0]  geat_q, geat_d;
`endif

   // Widened by one bit so the magnitude subtraction never wraps
   for (genvar g = 0; g < 4; g++) begin : g_hit
      logic [10:0] ax, ay, bx, by, dx, dy;
      assign ax = {1'b0, pac_x};
      assign ay = {1'b0, pac_y};
      assign bx = {1'b0, ghost_x[10*g +: 10]};
      assign by = {1'b0, ghost_y[10*g +: 10]};
      assign dx = (ax >= bx) ? ax - bx : bx - ax;
      assign dy = (ay >= by) ? ay - by : by - ay;
      assign hit[g] = (dx < HD) && (dy < HD);
   end

   always_comb begin
      logic        fatal;
      logic [7:0]  add;
      logic [16:0] sum;
      state_d  = state_q;
      lives_d  = lives_q;
      score_d  = score_q;
      pel_d    = pel_q;
      resp_d   = resp_q;
      death_d  = death_q;
      win_d    = win_q;
      fatal    = 1'b0;
      add      = 8'd0;
      sum      = 17'd0;
`ifdef POWER_PELLET_EN
      fright_d = fright_q;
      geat_d   = 4'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (gamescreen) begin
               lives_d = LI;
               score_d = 16'd0;
               pel_d   = PT;
               resp_d  = 16'd0;
               death_d = 1'b0;
               win_d   = 1'b0;
               state_d = PLAY;
`ifdef POWER_PELLET_EN
               fright_d = 16'd0;
`endif
            end
         end
         PLAY, RESPAWN: begin
            if (!gamescreen) begin
               state_d = IDLE;
               death_d = 1'b0;
               win_d   = 1'b0;
            end else begin
               if (pellet_eaten) begin
                  add = 8'd10;
                  if (pel_q != 8'd0)
                     pel_d = pel_q - 8'd1;
               end
`ifdef POWER_PELLET_EN
               if (power_pellet)
                  fright_d = FF;
               else if (frame_tick && fright_q != 16'd0)
                  fright_d = fright_q - 16'd1;
`endif
               if (state_q == PLAY) begin
                  if (frame_tick && |hit) begin
`ifdef POWER_PELLET_EN
                     if (fright_q != 16'd0) begin
                        geat_d = hit;
                        add    = add + 8'd200;
                     end else
`endif
                     if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        resp_d  = RF;
                        state_d = RESPAWN;
                     end else begin
                        lives_d = 2'd0;
                        fatal   = 1'b1;
                     end
                  end
               end else if (frame_tick) begin
                  if (resp_q != 16'd0)
                     resp_d = resp_q - 16'd1;
                  if (resp_q <= 16'd1)
                     state_d = PLAY;
               end
               sum = {1'b0, score_q} + 17'(add);
               score_d = sum[16] ? 16'hFFFF : sum[15:0];
               // Death outranks a simultaneous last pellet
               if (fatal) begin
                  death_d = 1'b1;
                  state_d = DEAD;
               end else if (pellet_eaten && pel_q == 8'd1) begin
                  win_d   = 1'b1;
                  state_d = WON;
               end
            end
         end
         DEAD, WON: begin
            if (!gamescreen) begin
               state_d = IDLE;
               death_d = 1'b0;
               win_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         lives_q  <= LI;
         score_q  <= 16'd0;
         pel_q    <= PT;
         resp_q   <= 16'd0;
         death_q  <= 1'b0;
         win_q    <= 1'b0;
`ifdef POWER_PELLET_EN
         fright_q <= 16'd0;
         geat_q   <= 4'b0;
`endif
      end else begin
         state_q  <= state_d;
         lives_q  <= lives_d;
         score_q  <= score_d;
         pel_q    <= pel_d;
         resp_q   <= resp_d;
         death_q  <= death_d;
         win_q    <= win_d;
`ifdef POWER_PELLET_EN
         fright_q <= fright_d;
         geat_q   <= geat_d;
`endif
      end
   end

   assign pacDeath     = death_q;
   assign winsignal    = win_q;
   assign lives        = lives_q;
   assign score        = score_q;
   assign pellets_left = pel_q;
`ifdef POWER_PELLET_EN
   assign ghost_eaten  = geat_q;
`endif

endmodule

// File: doc/game_status.md
GAME_STATUS -- requirements
Module: game_status

Interface
REQ-001 SHALL have parameter HIT_DIST, default 8, collision half-window in pixels.
REQ-002 SHALL have parameter PELLET_TOTAL, default 150, pellets per level (8-bit).
REQ-003 SHALL have parameter LIVES_INIT, default 3, lives at game start (2-bit).
REQ-004 SHALL have parameter RESPAWN_FRAMES, default 60, invulnerability frames after a life loss.
REQ-005 SHALL have port Clk, input, 1, sole clock.
REQ-006 SHALL have port Reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port gamescreen, input, 1, high while the screen FSM is in its Game state.
REQ-008 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-009 SHALL have ports pac_x and pac_y, input, 10 each, Pac-Man position.
REQ-010 SHALL have ports ghost_x and ghost_y, input, 40 each, ghost i at bits [10i+9:10i], i=0..3.
REQ-011 SHALL have port pellet_eaten, input, 1, one-cycle pulse per pellet consumed.
REQ-012 SHALL have port pacDeath, output, 1, level: all lives lost.
REQ-013 SHALL have port winsignal, output, 1, level: all pellets eaten.
REQ-014 SHALL have ports lives (output, 2), score (output, 16) and pellets_left (output, 8).

Function
REQ-015 SHALL implement states IDLE, PLAY, RESPAWN, DEAD, WON, with all outputs registered.
REQ-016 IDLE: on the first cycle with gamescreen=1, SHALL load lives=LIVES_INIT, score=0, pellets_left=PELLET_TOTAL and enter PLAY.
REQ-017 Collision SHALL mean, for any ghost i, |pac_x-ghost_x[i]|<HIT_DIST and |pac_y-ghost_y[i]|<HIT_DIST, computed with unsigned magnitude subtraction (no wrap).
REQ-018 PLAY: collision is sampled only on frame_tick cycles; a collision with lives>1 SHALL decrement lives, load the respawn counter with RESPAWN_FRAMES and enter RESPAWN.
REQ-019 PLAY: a collision with lives==1 SHALL set lives=0, assert pacDeath the next cycle and enter DEAD.
REQ-020 RESPAWN SHALL ignore collisions, decrement its counter on each frame_tick, and return to PLAY in the cycle after the tick that reaches 0.
REQ-021 In PLAY and RESPAWN, each pellet_eaten pulse SHALL decrement pellets_left (floor 0) and add 10 to score, saturating at 16'hFFFF.
REQ-022 When pellets_left transitions to 0, winsignal SHALL assert the next cycle and the state SHALL become WON.
REQ-023 When a fatal collision and the last pellet occur in the same cycle, death SHALL take priority: DEAD, pacDeath=1, winsignal=0, with score still updated.
REQ-024 DEAD and WON SHALL hold their flag, ignore pellet_eaten and frame_tick, and on gamescreen=0 clear both flags and enter IDLE.
REQ-025 gamescreen=0 in PLAY or RESPAWN SHALL force IDLE with the flags clear.
REQ-026 lives, score and pellets_left SHALL hold their values in IDLE until the next game start, so the end screens can display them.
REQ-027 pellet_eaten in IDLE SHALL be ignored.

Reset
REQ-028 On Reset=1 at a Clk edge: state=IDLE, pacDeath=0, winsignal=0, lives=LIVES_INIT, score=0, pellets_left=PELLET_TOTAL, respawn counter=0; Reset SHALL override all other inputs, including mid-game.

Configuration
REQ-029 Macro POWER_PELLET_EN, when defined, SHALL add input power_pellet (1), output ghost_eaten (4) and parameter FRIGHT_FRAMES (default 300).
REQ-030 With POWER_PELLET_EN, a power_pellet pulse SHALL load a fright counter with FRIGHT_FRAMES, which decrements on each frame_tick.
REQ-031 With POWER_PELLET_EN, a collision while the fright counter is non-zero SHALL cost no life, add 200 to score (saturating) and pulse ghost_eaten[i] for one cycle per colliding ghost.
REQ-032 Without POWER_PELLET_EN, those ports and logic SHALL be absent, and every collision SHALL follow REQ-018/REQ-019.

Verification
REQ-033 Reset, then gamescreen=1 with 150 pellet_eaten pulses -> winsignal=1 one cycle after the 150th pulse, score=1500, pellets_left=0, pacDeath=0.
REQ-034 pac=(100,100), ghost0=(105,96), frame_tick -> lives 3->2 and RESPAWN; ticks 1..59 with the ghost overlapping -> lives stay 2; PLAY resumes after tick 60.
REQ-035 Three separated fatal collisions -> pacDeath=1 one cycle after the third tick, lives=0; then gamescreen=0 -> pacDeath=0 and state IDLE.
REQ-036 lives=1, pellets_left=1, pellet_eaten and colliding frame_tick in the same cycle -> pacDeath=1, winsignal=0.
REQ-037 pac=(100,100), ghost0=(108,100) -> no collision (boundary); ghost0=(107,100) -> collision.
REQ-038 Reset asserted mid-RESPAWN with score=500 -> next cycle IDLE, score=0, lives=3, both flags 0.
